asp_net_rx: RTL and testbench

- Network-side receive stage that sits directly downstream of the ASP network transmit port.
- Consumes the {data, tag} words the ASP sends. Returns a one-cycle ACK for every word it accepts or recognises as a retransmission.
- Buffers accepted words in a small FIFO and drops duplicate retransmissions by tag.
- Delivers payload plus tag to the next consumer over a valid/ready handshake.

---
 rtl/asp_net_rx_pkg.sv | 25 ++
 rtl/asp_rx_fifo.sv | 54 +++++
 rtl/asp_net_rx.sv | 85 ++++++++
 tb/tb_asp_net_rx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/asp_net_rx_pkg.sv
// rtl/asp_net_rx_pkg.sv - shared widths, slice constants and offer classification
package asp_net_rx_pkg;

    localparam int DATA_SIZE = 32;
    localparam int TAG_SIZE  = 8;
    localparam int TAG_LSB   = 0;
    localparam int DATA_LSB  = TAG_SIZE;

    typedef enum logic [1:0] {
        OFFER_ACCEPT = 2'd0,
        OFFER_DUP    = 2'd1,
        OFFER_REJECT = 2'd2
    } offer_class_e;

    // A repeat of the last accepted tag is re-ACKed even when the buffer is full.
    function automatic offer_class_e classify(input logic tag_match, input logic has_room);
        if (tag_match)
            return OFFER_DUP;
        else if (has_room)
            return OFFER_ACCEPT;
        else
            return OFFER_REJECT;
    endfunction

endpackage

// File: rtl/asp_rx_fifo.sv
// rtl/asp_rx_fifo.sv - synchronous-reset receive FIFO with push/pop/full/empty/count
module asp_rx_fifo #(
    parameter int width = 40,
    parameter int depth = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [width-1:0]           push_data,
    input  logic                       pop,
    output logic [width-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(depth):0]     count
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < depth; i++)
                mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/asp_net_rx.sv
// rtl/asp_net_rx.sv - ASP network receive stage: ACK, duplicate drop, buffered delivery
module asp_net_rx
    import asp_net_rx_pkg::*;
#(
    parameter int data_size  = DATA_SIZE,
    parameter int tag_size   = TAG_SIZE,
    parameter int fifo_depth = 4,
    parameter int cnt_size   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          network_data_ready_in,
    input  logic [data_size+tag_size-1:0] network_data_tag_in,
    output logic                          network_ACK_out,
    output logic                          rx_valid_out,
    input  logic                          rx_ready_in,
    output logic [data_size-1:0]          rx_data_out,
    output logic [tag_size-1:0]           rx_tag_out,
    output logic                          fifo_full_out,
    output logic [cnt_size-1:0]           dup_count_out
);

    localparam int W  = data_size + tag_size;
    localparam int AW = $clog2(fifo_depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(fifo_depth);

    logic [W-1:0]        head;
    logic [AW:0]         occ;
    logic                full;
    logic                empty;
    logic [tag_size-1:0] tag_in;
    logic [tag_size-1:0] last_tag;
    logic                last_tag_valid;
    offer_class_e        cls;
    logic                push;
    logic                dup;

    assign tag_in = network_data_tag_in[TAG_LSB +: tag_size];

    // Classification uses occupancy from before this edge, so a same-cycle pop never frees a slot.
    always_comb begin
        cls = classify(last_tag_valid && (tag_in == last_tag), occ != FULL_CNT);
    end

    assign push = network_data_ready_in && (cls == OFFER_ACCEPT);
    assign dup  = network_data_ready_in && (cls == OFFER_DUP);

    asp_rx_fifo #(
        .width (W),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (network_data_tag_in),
        .pop       (rx_ready_in),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (occ)
    );

    assign rx_valid_out  = !empty;
    assign fifo_full_out = full;
    assign rx_data_out   = head[tag_size +: data_size];
    assign rx_tag_out    = head[TAG_LSB +: tag_size];

    always_ff @(posedge clk) begin
        if (reset) begin
            network_ACK_out <= 1'b0;
            last_tag        <= '0;
            last_tag_valid  <= 1'b0;
            dup_count_out   <= '0;
        end else begin
            network_ACK_out <= push || dup;
            if (push) begin
                last_tag       <= tag_in;
                last_tag_valid <= 1'b1;
            end
            if (dup && (dup_count_out != '1))
                dup_count_out <= dup_count_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_asp_net_rx.sv
// tb/tb_asp_net_rx.sv - randomized and directed bench for asp_net_rx against a queue model
module tb_asp_net_rx;

    localparam int DS    = 32;
    localparam int TS    = 8;
    localparam int DEPTH = 4;
    localparam int CS    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          network_data_ready_in;
    logic [DS+TS-1:0] network_data_tag_in;
    logic          network_ACK_out;
    logic          rx_valid_out;
    logic          rx_ready_in;
    logic [DS-1:0] rx_data_out;
    logic [TS-1:0] rx_tag_out;
    logic          fifo_full_out;
    logic [CS-1:0] dup_count_out;

    int checks = 0;
    int errors = 0;

    logic [DS+TS-1:0] m_q [$];
    logic [TS-1:0]    m_last;
    logic             m_last_valid;
    logic [CS-1:0]    m_dup;
    logic             m_ack;

    asp_net_rx #(
        .data_size  (DS),
        .tag_size   (TS),
        .fifo_depth (DEPTH),
        .cnt_size   (CS)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .network_data_ready_in (network_data_ready_in),
        .network_data_tag_in   (network_data_tag_in),
        .network_ACK_out       (network_ACK_out),
        .rx_valid_out          (rx_valid_out),
        .rx_ready_in           (rx_ready_in),
        .rx_data_out           (rx_data_out),
        .rx_tag_out            (rx_tag_out),
        .fifo_full_out         (fifo_full_out),
        .dup_count_out         (dup_count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
    task automatic step(input logic rst, input logic offer, input logic [TS-1:0] tag,
                        input logic [DS-1:0] data, input logic ready);
        logic was_full, is_dup, is_acc, do_pop;
        reset                 = rst;
        network_data_ready_in = offer;
        network_data_tag_in   = {data, tag};
        rx_ready_in           = ready;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_last_valid = 1'b0;
            m_last       = '0;
            m_dup        = '0;
            m_ack        = 1'b0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            is_dup   = offer && m_last_valid && (tag == m_last);
            is_acc   = offer && !was_full && !is_dup;
            do_pop   = (m_q.size() > 0) && ready;
            m_ack    = is_acc || is_dup;
            if (is_dup && m_dup != {CS{1'b1}})
                m_dup = m_dup + 1'b1;
            if (do_pop)
                void'(m_q.pop_front());
            if (is_acc) begin
                m_q.push_back({data, tag});
                m_last       = tag;
                m_last_valid = 1'b1;
            end
        end
        @(negedge clk);
        check("ack", 64'(network_ACK_out), 64'(m_ack));
        check("valid", 64'(rx_valid_out), 64'(m_q.size() > 0));
        check("full", 64'(fifo_full_out), 64'(m_q.size() == DEPTH));
        check("dup_count", 64'(dup_count_out), 64'(m_dup));
        if (m_q.size() > 0) begin
            check("head_data", 64'(rx_data_out), 64'(m_q[0][TS +: DS]));
            check("head_tag", 64'(rx_tag_out), 64'(m_q[0][TS-1:0]));
        end else if (rst) begin
            check("reset_data", 64'(rx_data_out), 64'd0);
            check("reset_tag", 64'(rx_tag_out), 64'd0);
        end
    endtask

    task automatic offer(input logic [TS-1:0] tag, input logic ready);
        step(1'b0, 1'b1, tag, $urandom, ready);
    endtask

    task automatic idle(input logic ready);
        step(1'b0, 1'b0, '0, '0, ready);
    endtask

    initial begin
        reset = 1'b1;
        network_data_ready_in = 1'b0;
        network_data_tag_in = '0;
        rx_ready_in = 1'b0;
        @(negedge clk);

        // single word
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b1, 8'h01, 32'hA5A5A5A5, 1'b0);
        check("t1_ack", 64'(network_ACK_out), 64'd1);
        check("t1_data", 64'(rx_data_out), 64'hA5A5A5A5);
        idle(1'b0);
        check("t1_ack_once", 64'(network_ACK_out), 64'd0);
        idle(1'b1);
        check("t1_drained", 64'(rx_valid_out), 64'd0);

        // duplicate
        step(1'b1, 1'b0, '0, '0, 1'b0);
        offer(8'h01, 1'b0);
        offer(8'h01, 1'b0);
        check("t2_dup", 64'(dup_count_out), 64'd1);
        idle(1'b1);
        check("t2_one_entry", 64'(rx_valid_out), 64'd0);

        // full / reject / retry
        for (int i = 2; i <= 5; i++) offer(8'(i), 1'b0);
        check("t3_full", 64'(fifo_full_out), 64'd1);
        offer(8'h06, 1'b0);
        check("t3_reject", 64'(network_ACK_out), 64'd0);
        idle(1'b1);
        offer(8'h06, 1'b0);
        check("t3_retry_ack", 64'(network_ACK_out), 64'd1);

        // full with same-cycle pop: offer rejected, occupancy drops to 3
        offer(8'h07, 1'b1);
        check("t4_reject", 64'(network_ACK_out), 64'd0);
        check("t4_not_full", 64'(fifo_full_out), 64'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // tag wrap streaming
        offer(8'hFE, 1'b1);
        offer(8'hFF, 1'b1);
        offer(8'h00, 1'b1);
        check("t5_ack", 64'(network_ACK_out), 64'd1);
        idle(1'b1);

        // reset mid-stream then re-offer previous last tag
        offer(8'h10, 1'b0);
        offer(8'h11, 1'b0);
        step(1'b1, 1'b1, 8'h12, '0, 1'b0);
        check("t6_no_ack", 64'(network_ACK_out), 64'd0);
        offer(8'h11, 1'b0);
        check("t6_accept", 64'(rx_tag_out), 64'h11);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [TS-1:0] t;
            t = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, t, $urandom,
                 $urandom_range(0, 9) < 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
